arc_octant_plotter: RTL
=======================

Name: arc_octant_plotter

Overview:
Parametrised successor to the fixed-shape drawing blocks. It generates midpoint-circle arcs about a centre, with these additions:
- a per-octant enable mask, so arcs can be composed into Reuleaux, semicircle and ring shapes;
- a programmable clip rectangle on top of screen bounds.

It sits between the shape-sequencing FSMs and the VGA adapter, emitting one candidate pixel per clock on the vga_* plot interface.

Parameters:
XW, 8, width of x coordinates
YW, 7, width of y coordinates
RW, 8, width of radius
SCREEN_W, 160, visible columns (x valid 0..SCREEN_W-1)
SCREEN_H, 120, visible rows (y valid 0..SCREEN_H-1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled in IDLE only
done  out  1  high in DONE state
colour  in  3  pixel colour, latched at start
centre_x  in  XW  arc centre x, latched at start
centre_y  in  YW  arc centre y, latched at start
radius  in  RW  arc radius, latched at start
octant_mask  in  8  bit k enables octant k, latched at start
clip_xmin  in  XW  inclusive clip bound, latched at start
clip_xmax  in  XW  inclusive clip bound, latched at start
clip_ymin  in  YW  inclusive clip bound, latched at start
clip_ymax  in  YW  inclusive clip bound, latched at start
vga_x  out  XW  pixel x (registered)
vga_y  out  YW  pixel y (registered)
vga_colour  out  3  pixel colour (registered)
vga_plot  out  1  pixel write strobe (registered)

Behaviour:
- Reset (asynchronous, any time including mid-draw):
  - state goes to IDLE;
  - done, vga_plot, vga_x, vga_y and vga_colour are all 0;
  - internal counters are cleared.
- States:
  - IDLE: start=1 latches all inputs, then goes to INIT.
  - INIT: one cycle. Sets ox=radius, oy=0, crit=1-radius, oct=0. Goes to PLOT.
  - PLOT: one cycle per octant, oct=0..7. Always 8 cycles per iteration, independent of mask. On oct=7, updates the algorithm. Goes to DONE if the new oy > ox, otherwise stays in PLOT with oct=0.
  - DONE: done=1. Stays while start=1; goes to IDLE when start=0.
- Algorithm update on oct=7:
  - oy += 1.
  - If crit <= 0: crit += 2*oy + 1.
  - Else: ox -= 1, then crit += 2*(oy-ox) + 1.
  - Both cases use the updated oy/ox values.
- Octant point for oct k (cx, cy are the latched centre):
  - 0: (cx+ox, cy+oy)
  - 1: (cx+oy, cy+ox)
  - 2: (cx-oy, cy+ox)
  - 3: (cx-ox, cy+oy)
  - 4: (cx-ox, cy-oy)
  - 5: (cx-oy, cy-ox)
  - 6: (cx+oy, cy-ox)
  - 7: (cx+ox, cy-oy)
- Arithmetic widths:
  - point coordinates are signed, XW+2 bits for x and YW+2 bits for y; no wrap permitted;
  - crit is signed, RW+3 bits.
- Plot qualification: vga_plot=1 in the cycle after a PLOT cycle iff all of:
  - octant_mask[k]=1;
  - 0 <= x < SCREEN_W and 0 <= y < SCREEN_H;
  - clip_xmin <= x <= clip_xmax and clip_ymin <= y <= clip_ymax.
- Output registers: vga_x/vga_y carry the truncated coordinate every PLOT cycle, qualified or not. vga_plot=0 in all other states.
- Latency: start edge to done=1 is 1 + 8*N + 1 cycles, where N = iteration count. The final vga_plot coincides with done's first cycle.
- Boundary cases:
  - radius=0 gives N=1: 8 points at the centre, duplicate plots permitted.
  - clip_xmin > clip_xmax (or ymin > ymax) gives an empty box: the full sequence runs with no plots.
  - start high while not in IDLE is ignored. Input changes after the start cycle have no effect.
  - start held high continuously gives one draw, then DONE until start drops.
  - Points are generated in the order given above; duplicates on diagonals and axes are not suppressed.

Test Plan:
- radius=0, centre (80,60), mask=8'hFF, clip full screen, colour=3'b101 -> exactly 8 vga_plot pulses at (80,60), colour 5; done=1 on cycle 10 after start edge.
- radius=1, centre (80,60), mask=8'hFF, full clip -> N=2, 16 pulses; (81,60),(80,61),(80,61),(79,60),(79,60),(80,59),(80,59),(81,60) then (81,61),(81,61),(79,61),(79,61),(79,59),(79,59),(81,59),(81,59); done on cycle 18.
- radius=10, centre (80,60), mask=8'h01, full clip -> only octant-0 points plotted, all with x>=80, y>=60 and (x-80)>=(y-60); first point (90,60); the pulse count equals N.
- radius=5, centre (2,2), mask=8'hFF, full clip -> no plot with x or y negative or wrapped (e.g. no x=253); points such as (7,2) and (2,7) are plotted.
- radius=20, centre (80,60), clip x 80..159, y 0..119 -> every plotted x>=80; point (60,60) is absent.
- Assert rst for 1 cycle mid-PLOT -> done=0 and vga_plot=0 immediately and asynchronously; a new start afterwards draws correctly from INIT.

Source files
------------

// File: rtl/arc_octant_plotter_if.sv
// Plot-request bus between a shape sequencer (master) and the arc plotter
// (slave): draw parameters and handshake in, VGA pixel stream out.
interface arc_octant_plotter_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int RW = 8
);
  logic          start;
  logic          done;
  logic [2:0]    colour;
  logic [XW-1:0] centre_x;
  logic [YW-1:0] centre_y;
  logic [RW-1:0] radius;
  logic [7:0]    octant_mask;
  logic [XW-1:0] clip_xmin;
  logic [XW-1:0] clip_xmax;
  logic [YW-1:0] clip_ymin;
  logic [YW-1:0] clip_ymax;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [2:0]    vga_colour;
  logic          vga_plot;

  modport master (
    output start, colour, centre_x, centre_y, radius, octant_mask,
           clip_xmin, clip_xmax, clip_ymin, clip_ymax,
    input  done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, colour, centre_x, centre_y, radius, octant_mask,
           clip_xmin, clip_xmax, clip_ymin, clip_ymax,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/arc_octant_plotter.sv
// Midpoint-circle arc generator: walks one octant step per iteration and
// emits the eight mirrored candidate pixels, gated by an octant mask, the
// screen bounds and a programmable clip rectangle.
module arc_octant_plotter #(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int RW       = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                  clk,
  input  logic                  rst,
  arc_octant_plotter_if.slave   bus
);

  // Point arithmetic is done wide enough that centre +/- radius can never
  // wrap, whatever the relative sizes of XW, YW and RW.
  localparam int W = XW + YW + RW + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_PLOT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic signed [RW+2:0] CRIT_ONE = {{(RW+2){1'b0}}, 1'b1};
  localparam logic signed [RW+1:0] STEP_ONE = {{(RW+1){1'b0}}, 1'b1};

  logic [1:0]             state_q, state_d;
  logic signed [RW+1:0]   ox_q, ox_d, oy_q, oy_d;
  logic signed [RW+2:0]   crit_q, crit_d;
  logic [2:0]             oct_q, oct_d;

  logic [2:0]             colour_q;
  logic [XW-1:0]          cx_q, xmin_q, xmax_q;
  logic [YW-1:0]          cy_q, ymin_q, ymax_q;
  logic [RW-1:0]          radius_q;
  logic [7:0]             mask_q;

  logic [XW-1:0]          vga_x_q;
  logic [YW-1:0]          vga_y_q;
  logic [2:0]             vga_colour_q;
  logic                   vga_plot_q;

  logic signed [W-1:0]    cxs, cys, oxs, oys, px, py;
  logic                   plotHit;
  logic signed [RW+1:0]   oyNext, oxNext;
  logic signed [RW+2:0]   critNext, critStep;

  // Mirror the current (ox, oy) into the active octant and qualify the point.
  always_comb begin
    cxs = $signed({{(W-XW){1'b0}}, cx_q});
    cys = $signed({{(W-YW){1'b0}}, cy_q});
    oxs = $signed({{(W-RW-2){ox_q[RW+1]}}, ox_q});
    oys = $signed({{(W-RW-2){oy_q[RW+1]}}, oy_q});
    px  = cxs + oxs;
    py  = cys + oys;
    case (oct_q)
      3'd0: begin px = cxs + oxs; py = cys + oys; end
      3'd1: begin px = cxs + oys; py = cys + oxs; end
      3'd2: begin px = cxs - oys; py = cys + oxs; end
      3'd3: begin px = cxs - oxs; py = cys + oys; end
      3'd4: begin px = cxs - oxs; py = cys - oys; end
      3'd5: begin px = cxs - oys; py = cys - oxs; end
      3'd6: begin px = cxs + oys; py = cys - oxs; end
      default: begin px = cxs + oxs; py = cys - oys; end
    endcase
    plotHit = mask_q[oct_q]
           && (px >= 0) && (px < W'(SCREEN_W))
           && (py >= 0) && (py < W'(SCREEN_H))
           && (px >= $signed({{(W-XW){1'b0}}, xmin_q}))
           && (px <= $signed({{(W-XW){1'b0}}, xmax_q}))
           && (py >= $signed({{(W-YW){1'b0}}, ymin_q}))
           && (py <= $signed({{(W-YW){1'b0}}, ymax_q}));
  end

  // Midpoint update, always computed from the already-stepped oy/ox.
  always_comb begin
    oyNext = oy_q + STEP_ONE;
    oxNext = ox_q;
    if (crit_q > 0) begin
      oxNext = ox_q - STEP_ONE;
    end
    if (crit_q <= 0) begin
      critStep = {oyNext[RW+1], oyNext};
    end else begin
      critStep = {oyNext[RW+1], oyNext} - {oxNext[RW+1], oxNext};
    end
    critNext = crit_q + critStep + critStep + CRIT_ONE;
  end

  // Sequencing FSM and iteration state.
  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    crit_d  = crit_q;
    oct_d   = oct_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_INIT;
      S_INIT: begin
        ox_d    = $signed({2'b00, radius_q});
        oy_d    = '0;
        crit_d  = CRIT_ONE - $signed({3'b000, radius_q});
        oct_d   = 3'd0;
        state_d = S_PLOT;
      end
      S_PLOT: begin
        oct_d = oct_q + 3'd1;
        if (oct_q == 3'd7) begin
          ox_d   = oxNext;
          oy_d   = oyNext;
          crit_d = critNext;
          if (oyNext > oxNext) state_d = S_DONE;
        end
      end
      default: if (!bus.start) state_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      crit_q  <= '0;
      oct_q   <= '0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      crit_q  <= crit_d;
      oct_q   <= oct_d;
    end
  end

  // Capture the draw request; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colour_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      radius_q <= '0;
      mask_q   <= '0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      ymax_q   <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      colour_q <= bus.colour;
      cx_q     <= bus.centre_x;
      cy_q     <= bus.centre_y;
      radius_q <= bus.radius;
      mask_q   <= bus.octant_mask;
      xmin_q   <= bus.clip_xmin;
      xmax_q   <= bus.clip_xmax;
      ymin_q   <= bus.clip_ymin;
      ymax_q   <= bus.clip_ymax;
    end
  end

  // Registered VGA outputs; coordinates follow every PLOT cycle, strobe only when qualified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else if (state_q == S_PLOT) begin
      vga_x_q      <= px[XW-1:0];
      vga_y_q      <= py[YW-1:0];
      vga_colour_q <= colour_q;
      vga_plot_q   <= plotHit;
    end else begin
      vga_plot_q   <= 1'b0;
    end
  end

  assign bus.done       = (state_q == S_DONE);
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;

endmodule
